// File: rtl/prog_clk_gen.sv
// prog_clk_gen: multi-channel programmable clock divider.
// Each channel divides fsys by a runtime-loadable divisor D (values 0/1 act as 2),
// emitting a registered divided clock (high for ceil(D/2), low for floor(D/2)),
// a one-cycle tick on the last fsys cycle of each period, and a busy flag.
// Divisor changes take effect only on period boundaries; disabling a channel
// lets the current period finish before the channel goes idle.
//
// Ports:
//   prog_clk_gen_fsys   in   system clock
//   prog_clk_gen_rst_n  in   asynchronous active-low reset
//   prog_clk_gen_en     in   [CHANNELS]           per-channel run enable (level)
//   prog_clk_gen_load   in   [CHANNELS]           per-channel divisor load strobe
//   prog_clk_gen_div    in   [CHANNELS*DIV_WIDTH] divisors, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   prog_clk_gen_out    out  [CHANNELS]           divided clock, registered
//   prog_clk_gen_tick   out  [CHANNELS]           end-of-period pulse, registered
//   prog_clk_gen_busy   out  [CHANNELS]           channel in RUN or DRAIN
module prog_clk_gen #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                          prog_clk_gen_fsys,
    input  logic                          prog_clk_gen_rst_n,
    input  logic [CHANNELS-1:0]           prog_clk_gen_en,
    input  logic [CHANNELS-1:0]           prog_clk_gen_load,
    input  logic [CHANNELS*DIV_WIDTH-1:0] prog_clk_gen_div,
    output logic [CHANNELS-1:0]           prog_clk_gen_out,
    output logic [CHANNELS-1:0]           prog_clk_gen_tick,
    output logic [CHANNELS-1:0]           prog_clk_gen_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        state_t                 r_state, w_state_nxt;
        logic [DIV_WIDTH-1:0]   r_a, w_a_nxt;
        logic [DIV_WIDTH-1:0]   r_p, w_p_nxt;
        logic [DIV_WIDTH-1:0]   r_c, w_c_nxt;
        logic                   r_f, w_f_nxt;
        logic                   r_out, w_out_nxt;
        logic                   r_tick, w_tick_nxt;
        logic [DIV_WIDTH-1:0]   w_div;
        logic [DIV_WIDTH-1:0]   w_d;
        logic [DIV_WIDTH-1:0]   w_half;
        logic                   w_wrap;
        logic                   w_active;

        assign w_div    = prog_clk_gen_div[i*DIV_WIDTH +: DIV_WIDTH];
        // Effective divisor clamps 0/1 to 2; half = ceil(D/2) without widening.
        assign w_d      = (r_a < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_a;
        assign w_half   = (w_d >> 1) + DIV_WIDTH'(w_d[0]);
        assign w_wrap   = (r_c == (w_d - DIV_WIDTH'(1)));
        assign w_active = (r_state != ST_IDLE);

        // State and datapath registers.
        always_ff @(posedge prog_clk_gen_fsys or negedge prog_clk_gen_rst_n) begin
            if (!prog_clk_gen_rst_n) begin
                r_state <= ST_IDLE;
                r_a     <= DIV_WIDTH'(2);
                r_p     <= '0;
                r_c     <= '0;
                r_f     <= 1'b0;
                r_out   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_a     <= w_a_nxt;
                r_p     <= w_p_nxt;
                r_c     <= w_c_nxt;
                r_f     <= w_f_nxt;
                r_out   <= w_out_nxt;
                r_tick  <= w_tick_nxt;
            end
        end

        // Next-state, counter, divisor update and output decode.
        always_comb begin
            w_state_nxt = r_state;
            w_a_nxt     = r_a;
            w_p_nxt     = r_p;
            w_c_nxt     = r_c;
            w_f_nxt     = r_f;
            w_out_nxt   = 1'b0;
            w_tick_nxt  = 1'b0;

            case (r_state)
                ST_IDLE: begin
                    w_c_nxt = '0;
                    if (r_f) begin
                        w_a_nxt = r_p;
                        w_f_nxt = 1'b0;
                    end
                    if (prog_clk_gen_en[i]) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    w_out_nxt  = (r_c < w_half);
                    w_tick_nxt = w_wrap;
                    w_c_nxt    = w_wrap ? '0 : (r_c + DIV_WIDTH'(1));
                    if (w_wrap && r_f) begin
                        w_a_nxt = r_p;
                        w_f_nxt = 1'b0;
                    end
                    if (r_state == ST_RUN) begin
                        // Disable exactly on a boundary stops without an extra drain period.
                        if (!prog_clk_gen_en[i]) begin
                            w_state_nxt = w_wrap ? ST_IDLE : ST_DRAIN;
                        end
                    end else begin
                        if (prog_clk_gen_en[i]) begin
                            w_state_nxt = ST_RUN;
                        end else if (w_wrap) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = '0;
                end
            endcase

            // A load landing on the wrap edge becomes active for the next period.
            if (prog_clk_gen_load[i]) begin
                w_p_nxt = w_div;
                w_f_nxt = 1'b1;
                if (w_active && w_wrap) begin
                    w_a_nxt = w_div;
                    w_f_nxt = 1'b0;
                end
            end
        end

        assign prog_clk_gen_out[i]  = r_out;
        assign prog_clk_gen_tick[i] = r_tick;
        assign prog_clk_gen_busy[i] = w_active;
    end

endmodule

// File: tb/tb_prog_clk_gen.sv
// tb_prog_clk_gen: directed self-checking bench for prog_clk_gen (4 channels, 16-bit divisors).
module tb_prog_clk_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 16;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    en;
    logic [CH-1:0]    load;
    logic [CH*DW-1:0] div;
    logic [CH-1:0]    out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    busy;

    int n_tests;
    int n_fail;

    prog_clk_gen #(.CHANNELS(CH), .DIV_WIDTH(DW)) dut (
        .prog_clk_gen_fsys  (clk),
        .prog_clk_gen_rst_n (rst_n),
        .prog_clk_gen_en    (en),
        .prog_clk_gen_load  (load),
        .prog_clk_gen_div   (div),
        .prog_clk_gen_out   (out),
        .prog_clk_gen_tick  (tick),
        .prog_clk_gen_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en    = '0;
        load  = '0;
        div   = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Load a divisor, then enable; returns with the channel in RUN and C=0.
    task automatic start(input int ch, input int d);
        div[ch*DW +: DW] = DW'(d);
        load[ch] = 1'b1;
        step();
        load[ch] = 1'b0;
        en[ch]   = 1'b1;
        step();
    endtask

    task automatic test_reset();
        en    = '0;
        load  = '0;
        div   = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out  !== 4'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out);  end
        n_tests++; if (tick !== 4'h0) begin n_fail++; $display("FAIL reset_tick got=%h exp=0", tick); end
        n_tests++; if (busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", busy); end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_tests++; if (busy !== 4'h0 || out !== 4'h0) begin
            n_fail++; $display("FAIL idle_after_reset busy=%h out=%h exp=0/0", busy, out);
        end
    endtask

    task automatic test_div5();
        logic [9:0] e_out;
        logic [9:0] e_tick;
        e_out  = 10'b0011100111;
        e_tick = 10'b1000010000;
        do_reset();
        start(0, 5);
        n_tests++; if (busy[0] !== 1'b1 || out[0] !== 1'b0) begin
            n_fail++; $display("FAIL div5_latency busy=%b out=%b exp=1/0", busy[0], out[0]);
        end
        for (int j = 0; j < 10; j++) begin
            step();
            n_tests++; if (out[0] !== e_out[j]) begin n_fail++; $display("FAIL div5_out j=%0d got=%b exp=%b", j, out[0], e_out[j]); end
            n_tests++; if (tick[0] !== e_tick[j]) begin n_fail++; $display("FAIL div5_tick j=%0d got=%b exp=%b", j, tick[0], e_tick[j]); end
            n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL div5_busy j=%0d got=%b exp=1", j, busy[0]); end
        end
    endtask

    task automatic test_div01();
        logic e;
        do_reset();
        div[0*DW +: DW] = DW'(0);
        div[1*DW +: DW] = DW'(1);
        load = 4'b0011;
        step();
        load = 4'b0000;
        en   = 4'b0011;
        step();
        for (int j = 0; j < 6; j++) begin
            step();
            e = (j % 2 == 0);
            n_tests++; if (out[1:0] !== {e, e}) begin n_fail++; $display("FAIL div01_out j=%0d got=%b exp=%b%b", j, out[1:0], e, e); end
            n_tests++; if (tick[1:0] !== {!e, !e}) begin n_fail++; $display("FAIL div01_tick j=%0d got=%b exp=%b%b", j, tick[1:0], !e, !e); end
        end
        n_tests++; if (busy[3:2] !== 2'b00 || out[3:2] !== 2'b00) begin
            n_fail++; $display("FAIL div01_others busy=%b out=%b exp=00/00", busy[3:2], out[3:2]);
        end
    endtask

    task automatic test_reload();
        logic [9:0] e_out;
        logic [9:0] e_tick;
        e_out  = 10'b0001111001;
        e_tick = 10'b1000000100;
        do_reset();
        start(0, 4);
        step();
        n_tests++; if (out[0] !== 1'b1) begin n_fail++; $display("FAIL reload_c0 got=%b exp=1", out[0]); end
        div[0*DW +: DW] = DW'(7);
        load[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            load[0] = 1'b0;
            n_tests++; if (out[0] !== e_out[j]) begin n_fail++; $display("FAIL reload_out j=%0d got=%b exp=%b", j, out[0], e_out[j]); end
            n_tests++; if (tick[0] !== e_tick[j]) begin n_fail++; $display("FAIL reload_tick j=%0d got=%b exp=%b", j, tick[0], e_tick[j]); end
        end
    endtask

    task automatic test_overwrite_wrap();
        logic [7:0] e_out;
        logic [7:0] e_tick;
        e_out  = 8'b00111011;
        e_tick = 8'b10000100;
        do_reset();
        start(0, 4);
        step();
        div[0*DW +: DW] = DW'(9);
        load[0] = 1'b1;
        step();
        div[0*DW +: DW] = DW'(3);
        step();
        load[0] = 1'b0;
        step();
        n_tests++; if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL overwrite_tick got=%b exp=1", tick[0]); end
        // Next period uses 3; a load at its wrap edge makes the following period 5.
        for (int j = 0; j < 8; j++) begin
            if (j == 2) begin
                div[0*DW +: DW] = DW'(5);
                load[0] = 1'b1;
            end
            step();
            load[0] = 1'b0;
            n_tests++; if (out[0] !== e_out[j]) begin n_fail++; $display("FAIL wrapload_out j=%0d got=%b exp=%b", j, out[0], e_out[j]); end
            n_tests++; if (tick[0] !== e_tick[j]) begin n_fail++; $display("FAIL wrapload_tick j=%0d got=%b exp=%b", j, tick[0], e_tick[j]); end
        end
    endtask

    task automatic test_drain();
        logic [4:0] e_out;
        logic [4:0] e_tick;
        logic [4:0] e_busy;
        logic [7:0] r_out;
        logic [7:0] r_tick;
        e_out  = 5'b00001;
        e_tick = 5'b01000;
        e_busy = 5'b00111;
        r_out  = 8'b00011100;
        r_tick = 8'b10000010;
        do_reset();
        start(0, 6);
        step();
        step();
        en[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            n_tests++; if (out[0] !== e_out[j]) begin n_fail++; $display("FAIL drain_out j=%0d got=%b exp=%b", j, out[0], e_out[j]); end
            n_tests++; if (tick[0] !== e_tick[j]) begin n_fail++; $display("FAIL drain_tick j=%0d got=%b exp=%b", j, tick[0], e_tick[j]); end
            n_tests++; if (busy[0] !== e_busy[j]) begin n_fail++; $display("FAIL drain_busy j=%0d got=%b exp=%b", j, busy[0], e_busy[j]); end
        end
        do_reset();
        start(0, 6);
        step();
        step();
        en[0] = 1'b0;
        step();
        step();
        en[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            n_tests++; if (out[0] !== r_out[j]) begin n_fail++; $display("FAIL rerun_out j=%0d got=%b exp=%b", j, out[0], r_out[j]); end
            n_tests++; if (tick[0] !== r_tick[j]) begin n_fail++; $display("FAIL rerun_tick j=%0d got=%b exp=%b", j, tick[0], r_tick[j]); end
            n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL rerun_busy j=%0d got=%b exp=1", j, busy[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e_out;
        logic [7:0] e_tick;
        e_out  = 8'b00001111;
        e_tick = 8'b10000000;
        do_reset();
        start(0, 8);
        step();
        step();
        step();
        n_tests++; if (out[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", out[0]); end
        #2;
        rst_n = 1'b0;
        en    = '0;
        #1;
        n_tests++; if (out[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got=%b exp=0", out[0]); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy[0]); end
        n_tests++; if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_tick got=%b exp=0", tick[0]); end
        step();
        rst_n = 1'b1;
        step();
        start(0, 8);
        for (int j = 0; j < 8; j++) begin
            step();
            n_tests++; if (out[0] !== e_out[j]) begin n_fail++; $display("FAIL rstmid_out8 j=%0d got=%b exp=%b", j, out[0], e_out[j]); end
            n_tests++; if (tick[0] !== e_tick[j]) begin n_fail++; $display("FAIL rstmid_tick8 j=%0d got=%b exp=%b", j, tick[0], e_tick[j]); end
        end
    endtask

    task automatic test_multi();
        int         dv [CH];
        logic [3:0] e_out;
        logic [3:0] e_tick;
        dv[0] = 2; dv[1] = 3; dv[2] = 5; dv[3] = 16;
        do_reset();
        for (int c = 0; c < int'(CH); c++) div[c*DW +: DW] = DW'(dv[c]);
        load = 4'hF;
        step();
        load = 4'h0;
        en   = 4'hF;
        step();
        for (int j = 0; j < 48; j++) begin
            step();
            for (int c = 0; c < int'(CH); c++) begin
                e_out[c]  = ((j % dv[c]) < ((dv[c] + 1) / 2));
                e_tick[c] = ((j % dv[c]) == dv[c] - 1);
            end
            n_tests++; if (out !== e_out) begin n_fail++; $display("FAIL multi_out j=%0d got=%b exp=%b", j, out, e_out); end
            n_tests++; if (tick !== e_tick) begin n_fail++; $display("FAIL multi_tick j=%0d got=%b exp=%b", j, tick, e_tick); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_div5();
        test_div01();
        test_reload();
        test_overwrite_wrap();
        test_drain();
        test_reset_mid();
        test_multi();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
